bcd_to_bin_seq: RTL and testbench

//  Sequential BCD-to-binary converter; the inverse of the binary-to-BCD display path.
//  It converts user-entered BCD digits (step goal, age, weight from the board switches)

---
 rtl/fitbit_pkg.sv | 20 ++
 rtl/bcd_digit_adj.sv | 12 +
 rtl/bcd_to_bin_seq.sv | 127 ++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fitbit_pkg.sv
// Shared constants and helpers for the board's BCD/binary conversion paths.
// Holds FSM encodings and the BCD digit validity check.
package fitbit_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;

    localparam int         BCD_DIGIT_W   = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_SHIFT = SHIFT
    } state_t;

    function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
        return d > BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: a shifted digit of 8 or more gets 3 removed.
// Purely combinational, no latency, no flow control.
module bcd_digit_adj
    import fitbit_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= 4'd8) ? (digit_i - 4'd3) : digit_i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one shift per clock.
// done follows the accepting edge by BIN_W clocks; start while busy is dropped.
module bcd_to_bin_seq
    import fitbit_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          busy,
    output logic                          done,
    output logic [BIN_W-1:0]              binary,
    output logic                          err,
    output logic                          ovf
);

    localparam int SW = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    state_t          state_q, state_d;
    logic [SW-1:0]   sreg_q, sreg_d, sreg_sh, sreg_adj;
    logic [BIN_W-1:0] breg_q, breg_d, breg_sh;
    logic [BIN_W-1:0] binary_q, binary_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            ovf_q, ovf_d;
    logic            bcd_bad;

    always_comb begin
        bcd_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_invalid(bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                bcd_bad = 1'b1;
            end
        end
    end

    // The BCD register drains into the binary register one bit per step.
    assign {sreg_sh, breg_sh} = {sreg_q, breg_q} >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (sreg_sh[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (sreg_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        breg_d   = breg_q;
        cnt_d    = cnt_q;
        binary_d = binary_q;
        err_d    = err_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (bcd_bad) begin
                        done_d   = 1'b1;
                        err_d    = 1'b1;
                        ovf_d    = 1'b0;
                        binary_d = '0;
                    end else begin
                        sreg_d  = bcd;
                        breg_d  = '0;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        ovf_d   = 1'b0;
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                sreg_d = sreg_adj;
                breg_d = breg_sh;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(BIN_W - 1)) begin
                    // Anything left in the BCD register is weight >= 2**BIN_W.
                    binary_d = breg_sh;
                    ovf_d    = |sreg_adj;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_SHIFT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sreg_q   <= '0;
            breg_q   <= '0;
            cnt_q    <= '0;
            binary_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            breg_q   <= breg_d;
            cnt_q    <= cnt_d;
            binary_q <= binary_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign binary = binary_q;
    assign err    = err_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboarded bench for bcd_to_bin_seq: default 2-digit instance plus two 3-digit instances.
module tb_bcd_to_bin_seq;

    typedef struct {
        logic [6:0] bin;
        logic       err;
        logic       ovf;
        int         lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  bcd;
    logic        busy, done, err, ovf;
    logic [6:0]  binary;

    logic        start3, busy3, done3, err3, ovf3;
    logic [11:0] bcd3;
    logic [9:0]  binary3;
    logic        start8, busy8, done8, err8, ovf8;
    logic [11:0] bcd8;
    logic [7:0]  binary8;

    int   n_chk = 0;
    int   n_fail = 0;
    int   n;
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) u_dut (
        .clk(clk), .reset(reset), .start(start), .bcd(bcd),
        .busy(busy), .done(done), .binary(binary), .err(err), .ovf(ovf)
    );

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .bcd(bcd3),
        .busy(busy3), .done(done3), .binary(binary3), .err(err3), .ovf(ovf3)
    );

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .bcd(bcd8),
        .busy(busy8), .done(done8), .binary(binary8), .err(err8), .ovf(ovf8)
    );

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] v);
        exp_t       e;
        logic [3:0] hi, lo;
        hi    = v[7:4];
        lo    = v[3:0];
        e.err = (hi > 4'd9) || (lo > 4'd9);
        e.ovf = 1'b0;
        e.bin = e.err ? 7'd0 : 7'(hi * 10 + lo);
        e.lat = e.err ? 0 : 7;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                chk_eq("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk_eq("binary", {25'd0, binary}, {25'd0, mon_e.bin});
                chk_eq("err", {31'd0, err}, {31'd0, mon_e.err});
                chk_eq("ovf", {31'd0, ovf}, {31'd0, mon_e.ovf});
                chk_eq("busy_in_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Call at a falling edge; returns at the falling edge where done is seen.
    task automatic run_conv(input logic [7:0] v, input bit inj);
        exp_t e;
        int   lat;
        int   nb;
        e     = model(v);
        start = 1'b1;
        bcd   = v;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        bcd   = 8'($urandom);
        lat   = 0;
        nb    = 0;
        while (!done && lat < 40) begin
            if (busy) nb++;
            if (inj && lat == 2) begin
                start = 1'b1;
                bcd   = 8'h13;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk_eq("done_seen", {31'd0, done}, 32'd1);
        chk_eq("latency", lat, e.lat);
        chk_eq("busy_cycles", nb, e.lat);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        bcd    = '0;
        start3 = 1'b0;
        bcd3   = '0;
        start8 = 1'b0;
        bcd8   = '0;
        #12;
        chk_eq("rst_busy", {31'd0, busy}, 32'd0);
        chk_eq("rst_done", {31'd0, done}, 32'd0);
        chk_eq("rst_binary", {25'd0, binary}, 32'd0);
        chk_eq("rst_err", {31'd0, err}, 32'd0);
        chk_eq("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_conv(8'h99, 1'b0);
        @(negedge clk);
        run_conv(8'h00, 1'b0);
        run_conv(8'h57, 1'b0);
        @(negedge clk);

        run_conv(8'h4A, 1'b0);
        repeat (2) @(negedge clk);
        chk_eq("err_held", {31'd0, err}, 32'd1);
        chk_eq("err_bin_held", {25'd0, binary}, 32'd0);
        run_conv(8'hF0, 1'b0);
        @(negedge clk);

        run_conv(8'h42, 1'b1);
        repeat (12) @(negedge clk);
        chk_eq("dropped_req", sb_q.size(), 32'd0);
        chk_eq("bin_held", {25'd0, binary}, 32'd42);

        start = 1'b1;
        bcd   = 8'h88;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_eq("mid_conv_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk_eq("abort_busy", {31'd0, busy}, 32'd0);
        chk_eq("abort_done", {31'd0, done}, 32'd0);
        chk_eq("abort_binary", {25'd0, binary}, 32'd0);
        chk_eq("abort_err", {31'd0, err}, 32'd0);
        chk_eq("abort_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        run_conv(8'h21, 1'b0);

        for (int i = 0; i < 16; i++) begin
            logic [7:0] v;
            if (i % 4 == 3) v = 8'($urandom);
            else v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if (i % 3 == 0) @(negedge clk);
            run_conv(v, 1'b0);
        end
        repeat (3) @(negedge clk);
        chk_eq("sb_drained", sb_q.size(), 32'd0);

        start3 = 1'b1;
        bcd3   = 12'h999;
        start8 = 1'b1;
        bcd8   = 12'h300;
        @(negedge clk);
        start3 = 1'b0;
        start8 = 1'b0;
        bcd3   = '0;
        bcd8   = '0;
        n = 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk_eq("w8_latency", n, 32'd8);
        chk_eq("w8_binary", {24'd0, binary8}, 32'd44);
        chk_eq("w8_ovf", {31'd0, ovf8}, 32'd1);
        chk_eq("w8_err", {31'd0, err8}, 32'd0);
        while (!done3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk_eq("w10_latency", n, 32'd10);
        chk_eq("w10_binary", {22'd0, binary3}, 32'd999);
        chk_eq("w10_ovf", {31'd0, ovf3}, 32'd0);
        chk_eq("w10_err", {31'd0, err3}, 32'd0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
